// File: rtl/uart_out_buffer_pkg.sv
// Shared constants and types for the UART output buffer slice.
package uart_out_buffer_pkg;

    localparam int unsigned LEN_WORD           = 32;
    localparam int unsigned LEN_UART_SIZE      = 2;
    localparam int unsigned UART_BUF_DEPTH_LOG = 4;

    // Size field holds bytes-to-send minus one.
    localparam logic [LEN_UART_SIZE-1:0] UART_SIZE_1B = 2'b00;
    localparam logic [LEN_UART_SIZE-1:0] UART_SIZE_2B = 2'b01;
    localparam logic [LEN_UART_SIZE-1:0] UART_SIZE_3B = 2'b10;
    localparam logic [LEN_UART_SIZE-1:0] UART_SIZE_4B = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } uart_tx_state_t;

endpackage

// File: rtl/uart_out_buffer_if.sv
// CPU request group plus byte stream toward the UART transmitter.
interface uart_out_buffer_if
    import uart_out_buffer_pkg::*;
#(
    parameter int unsigned LEN_WORD = 32
) ();

    logic [LEN_UART_SIZE-1:0] uart_size_in;
    logic [LEN_WORD-1:0]      uart_o_data_in;
    logic                     uart_write_in;
    logic                     uart_accepted_out;
    logic [7:0]               tx_data_out;
    logic                     tx_valid_out;
    logic                     tx_ready_in;

    // Environment side: issues requests, consumes bytes.
    modport master (
        output uart_size_in, uart_o_data_in, uart_write_in, tx_ready_in,
        input  uart_accepted_out, tx_data_out, tx_valid_out
    );

    // Buffer side.
    modport slave (
        input  uart_size_in, uart_o_data_in, uart_write_in, tx_ready_in,
        output uart_accepted_out, tx_data_out, tx_valid_out
    );

endinterface

// File: rtl/uart_out_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop ignored when full/empty.
module sync_fifo #(
    parameter int unsigned WIDTH     = 34,
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_COUNT = DEPTH[DEPTH_LOG:0];

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_out_buffer.sv
// Queues 1-4 byte CPU output requests and serialises them LSB-first.
module uart_out_buffer
    import uart_out_buffer_pkg::*;
#(
    parameter int unsigned LEN_WORD  = 32,
    parameter int unsigned DEPTH_LOG = UART_BUF_DEPTH_LOG
) (
    input  logic               clk,
    input  logic               rst,
    uart_out_buffer_if.slave   bus,
    output logic               busy_out,
    output logic [DEPTH_LOG:0] count_out
);

    localparam int unsigned FIFO_W = LEN_WORD + LEN_UART_SIZE;

    uart_tx_state_t           state;
    uart_tx_state_t           state_nxt;
    logic                     accepted_q;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     hs;
    logic                     tx_valid;
    logic [FIFO_W-1:0]        fifo_rd;
    logic [LEN_WORD-1:0]      sh;
    logic [LEN_UART_SIZE-1:0] rem;

    // A held request is not re-queued in the cycle its accept pulse is visible.
    assign push = bus.uart_write_in && !full && !accepted_q;
    assign hs   = (state == S_SEND) && bus.tx_ready_in;

    sync_fifo #(
        .WIDTH     (FIFO_W),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.uart_size_in, bus.uart_o_data_in}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (full),
        .empty     (empty),
        .count     (count_out)
    );

    // Accept pulse: high for the one cycle after an enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_q <= 1'b0;
        end else begin
            accepted_q <= push;
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Serialiser next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!empty) state_nxt = S_SEND;
            S_SEND: if (hs && rem == '0 && empty) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Serialiser outputs; a pop on the last byte keeps the stream gap-free.
    always_comb begin
        pop      = 1'b0;
        tx_valid = 1'b0;
        case (state)
            S_IDLE: pop = !empty;
            S_SEND: begin
                tx_valid = 1'b1;
                pop      = hs && rem == '0 && !empty;
            end
            default: begin
                pop      = 1'b0;
                tx_valid = 1'b0;
            end
        endcase
    end

    // Shift register and remaining-byte counter; held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            rem <= '0;
        end else if (pop) begin
            sh  <= fifo_rd[LEN_WORD-1:0];
            rem <= fifo_rd[LEN_WORD +: LEN_UART_SIZE];
        end else if (hs && rem != '0) begin
            sh  <= sh >> 8;
            rem <= rem - 1'b1;
        end
    end

    assign bus.uart_accepted_out = accepted_q;
    assign bus.tx_valid_out      = tx_valid;
    assign bus.tx_data_out       = sh[7:0];
    assign busy_out              = (count_out != '0) || (state == S_SEND);

endmodule

// File: tb/tb_uart_out_buffer.sv
// Directed self-checking bench for uart_out_buffer.
module tb_uart_out_buffer;
    import uart_out_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [4:0] count;

    uart_out_buffer_if #(.LEN_WORD(32)) bus ();

    uart_out_buffer #(
        .LEN_WORD  (32),
        .DEPTH_LOG (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy_out  (busy),
        .count_out (count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    logic [7:0]  got_b[$];
    int unsigned got_c[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte collector and stall-stability monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_stable", {23'b0, bus.tx_valid_out, bus.tx_data_out},
                      {23'b0, 1'b1, prev_data});
            end
            if (bus.tx_valid_out && bus.tx_ready_in) begin
                got_b.push_back(bus.tx_data_out);
                got_c.push_back(cyc);
            end
            prev_stall = bus.tx_valid_out && !bus.tx_ready_in;
            prev_data  = bus.tx_data_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_b.delete();
        got_c.delete();
    endtask

    task automatic send(input logic [1:0] sz, input logic [31:0] d);
        logic seen;
        seen = 1'b0;
        bus.uart_size_in   = sz;
        bus.uart_o_data_in = d;
        bus.uart_write_in  = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = bus.uart_accepted_out;
        end
        bus.uart_write_in = 1'b0;
        check("accept", 32'(seen), 32'd1);
    endtask

    task automatic drain(input int unsigned n);
        for (int i = 0; i < 200 && got_b.size() < n; i++) tick();
        check("nbytes", 32'(got_b.size()), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acc"},   32'(bus.uart_accepted_out), 32'd0);
        check({tag, "_valid"}, 32'(bus.tx_valid_out), 32'd0);
        check({tag, "_data"},  32'(bus.tx_data_out), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int unsigned acc_cyc;
        logic        acc_seen;

        bus.uart_size_in   = '0;
        bus.uart_o_data_in = '0;
        bus.uart_write_in  = 1'b0;
        bus.tx_ready_in    = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single 4-byte request, receiver always ready
        clear_got();
        bus.tx_ready_in    = 1'b1;
        bus.uart_size_in   = UART_SIZE_4B;
        bus.uart_o_data_in = 32'hDDCCBBAA;
        bus.uart_write_in  = 1'b1;
        tick();
        check("t4_acc", 32'(bus.uart_accepted_out), 32'd1);
        check("t4_count", 32'(count), 32'd1);
        bus.uart_write_in = 1'b0;
        acc_cyc = cyc;
        tick();
        check("t4_acc_pulse", 32'(bus.uart_accepted_out), 32'd0);
        check("t4_first_valid", 32'(bus.tx_valid_out), 32'd1);
        check("t4_first_data", 32'(bus.tx_data_out), 32'hAA);
        drain(4);
        check("t4_b0", 32'(got_b[0]), 32'hAA);
        check("t4_b1", 32'(got_b[1]), 32'hBB);
        check("t4_b2", 32'(got_b[2]), 32'hCC);
        check("t4_b3", 32'(got_b[3]), 32'hDD);
        check("t4_latency", got_c[0] - acc_cyc, 32'd1);
        check("t4_consecutive", got_c[3] - got_c[0], 32'd3);
        check("t4_idle_valid", 32'(bus.tx_valid_out), 32'd0);
        check("t4_idle_busy", 32'(busy), 32'd0);

        // Size truncation, two requests streamed without a bubble
        clear_got();
        bus.tx_ready_in = 1'b0;
        send(UART_SIZE_1B, 32'h12345678);
        send(UART_SIZE_2B, 32'hCAFEBEEF);
        check("trunc_count", 32'(count), 32'd1);
        bus.tx_ready_in = 1'b1;
        drain(3);
        check("trunc_b0", 32'(got_b[0]), 32'h78);
        check("trunc_b1", 32'(got_b[1]), 32'hEF);
        check("trunc_b2", 32'(got_b[2]), 32'hBE);
        check("trunc_nobubble", got_c[2] - got_c[0], 32'd2);
        check("trunc_busy", 32'(busy), 32'd0);

        // Backpressure with ready pattern 1,0,0,1
        clear_got();
        bus.tx_ready_in = 1'b0;
        send(UART_SIZE_4B, 32'h44332211);
        send(UART_SIZE_2B, 32'h00006655);
        for (int i = 0; i < 60 && got_b.size() < 6; i++) begin
            bus.tx_ready_in = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        check("bp_nbytes", 32'(got_b.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("bp_byte", 32'(got_b[i]), 32'h11 * (i + 1));
        end
        bus.tx_ready_in = 1'b1;
        tick();
        check("bp_busy", 32'(busy), 32'd0);

        // Full FIFO: one entry in the serialiser, sixteen queued, next held
        clear_got();
        bus.tx_ready_in = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(UART_SIZE_1B, 32'(i));
        end
        check("full_count", 32'(count), 32'd16);
        bus.uart_size_in   = UART_SIZE_1B;
        bus.uart_o_data_in = 32'h11;
        bus.uart_write_in  = 1'b1;
        acc_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc_seen = acc_seen | bus.uart_accepted_out;
        end
        check("full_no_accept", 32'(acc_seen), 32'd0);
        check("full_count_held", 32'(count), 32'd16);
        check("full_busy", 32'(busy), 32'd1);
        bus.tx_ready_in = 1'b1;
        send(UART_SIZE_1B, 32'h11);
        drain(18);
        for (int i = 0; i < 18; i++) begin
            check("full_order", 32'(got_b[i]), 32'(i));
        end

        // Write held across its accept pulse enqueues once
        clear_got();
        bus.tx_ready_in    = 1'b0;
        bus.uart_size_in   = UART_SIZE_1B;
        bus.uart_o_data_in = 32'h0000005A;
        bus.uart_write_in  = 1'b1;
        tick();
        check("held_acc", 32'(bus.uart_accepted_out), 32'd1);
        tick();
        check("held_acc_drop", 32'(bus.uart_accepted_out), 32'd0);
        check("held_count", 32'(count), 32'd0);
        bus.uart_write_in = 1'b0;
        bus.tx_ready_in   = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("held_nbytes", 32'(got_b.size()), 32'd1);
        check("held_byte", 32'(got_b[0]), 32'h5A);

        // Reset mid-request with three queued
        clear_got();
        bus.tx_ready_in = 1'b0;
        send(UART_SIZE_4B, 32'h04030201);
        send(UART_SIZE_4B, 32'h14131211);
        send(UART_SIZE_4B, 32'h24232221);
        send(UART_SIZE_4B, 32'h34333231);
        check("rst_pre_count", 32'(count), 32'd3);
        bus.tx_ready_in = 1'b1;
        tick();
        check("rst_pre_byte2", 32'(bus.tx_data_out), 32'h02);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        clear_got();
        send(UART_SIZE_2B, 32'h0000A5C3);
        drain(2);
        for (int i = 0; i < 8; i++) tick();
        check("rst_after_nbytes", 32'(got_b.size()), 32'd2);
        check("rst_after_b0", 32'(got_b[0]), 32'hC3);
        check("rst_after_b1", 32'(got_b[1]), 32'hA5);
        check("rst_after_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
